// File: rtl/reservoir_history_reader.sv
// ----------------------------------------------------------------------------
// reservoir_history_reader
//
// Reads a window of samples back from the reservoir history RAM and presents
// them as a valid/ready stream. A start pulse (accepted only in IDLE) captures
// a base address and a sample count. The block then issues sequential RAM
// reads, wrapping modulo 2^ADDR_WIDTH. A 4-entry FIFO absorbs the 1-cycle
// RAM read latency, so one beat per clock is sustained while m_ready is high.
//
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   start        - request pulse, sampled only in IDLE
//   base_addr    - first RAM address of the window
//   num_samples  - window length, 0 .. 2^ADDR_WIDTH (0 => immediate done)
//   busy         - transfer in progress
//   done         - one-cycle pulse after the final beat's handshake
//   ram_ren      - RAM read enable
//   ram_addr     - RAM read address
//   ram_dout     - RAM read data, valid one cycle after ram_ren
//   m_data       - stream data (FIFO head)
//   m_valid      - stream valid
//   m_ready      - stream ready
//   m_last       - final sample of the transfer, qualified by m_valid
// ----------------------------------------------------------------------------
module reservoir_history_reader #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_samples,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_ren,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;

    // Captured transfer length, reads still to issue, beats already popped.
    logic [ADDR_WIDTH:0] num_q;
    logic [ADDR_WIDTH:0] rd_left;
    logic [ADDR_WIDTH:0] beat_cnt;

    // Read pipeline: [0] read issued this cycle (drives ram_ren),
    //                [1] its data is on ram_dout and is pushed this cycle.
    logic [1:0] vld_pipe;

    // FIFO storage and pointers.
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_mem;
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_count;

    logic [2:0] occupancy;
    logic       can_issue;
    logic       issue_next;
    logic       push;
    logic       pop;
    logic       last_beat;

    // ------------------------------------------------------------------
    // Stream side
    // ------------------------------------------------------------------
    assign ram_ren   = vld_pipe[0];
    assign push      = vld_pipe[1];
    assign m_valid   = (fifo_count != 3'd0);
    assign m_data    = fifo_mem[rd_ptr];
    assign last_beat = (beat_cnt == num_q - (ADDR_WIDTH+1)'(1));
    assign m_last    = m_valid && last_beat;
    assign pop       = m_valid && m_ready;

    // Buffered plus in-flight entries, from registered state only. Gating new
    // reads on this (ignoring a same-cycle pop) keeps the total at or below
    // FIFO_DEPTH, so a push can never find the FIFO full.
    assign occupancy = fifo_count + {2'b00, vld_pipe[0]} + {2'b00, vld_pipe[1]};
    assign can_issue = (occupancy < 3'(FIFO_DEPTH)) && (rd_left != '0);

    // Whether a read is issued in the next cycle.
    always_comb begin
        issue_next = 1'b0;
        case (state)
            IDLE:    issue_next = start && (num_samples != '0);
            READ:    issue_next = can_issue;
            default: issue_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], issue_next};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ram_addr <= '0;
            num_q    <= '0;
            rd_left  <= '0;
            beat_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (pop) begin
                beat_cnt <= beat_cnt + (ADDR_WIDTH+1)'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_samples == '0) begin
                            done <= 1'b1;
                        end else begin
                            // The first read goes out in the next cycle, so
                            // rd_left already excludes it.
                            num_q    <= num_samples;
                            rd_left  <= num_samples - (ADDR_WIDTH+1)'(1);
                            ram_addr <= base_addr;
                            beat_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= (num_samples == (ADDR_WIDTH+1)'(1)) ? DRAIN : READ;
                        end
                    end
                end

                READ: begin
                    // ram_addr holds the address of the most recent read.
                    // Wrap-around falls out of the ADDR_WIDTH-bit add.
                    if (can_issue) begin
                        ram_addr <= ram_addr + ADDR_WIDTH'(1);
                        rd_left  <= rd_left - (ADDR_WIDTH+1)'(1);
                        if (rd_left == (ADDR_WIDTH+1)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // The m_last beat is the last read's data, so once it is
                    // handshaken nothing is left buffered or in flight.
                    if (pop && last_beat) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= ram_dout;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_reservoir_history_reader.sv
module tb_reservoir_history_reader;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_samples;
    logic          busy, done, ram_ren;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout = '0;
    logic [DW-1:0] m_data;
    logic          m_valid, m_ready, m_last;

    reservoir_history_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_samples(num_samples), .busy(busy), .done(done),
        .ram_ren(ram_ren), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // History RAM preloaded with mem[a] = a, 1-cycle read latency.
    always @(posedge clk) if (ram_ren) ram_dout <= DW'(ram_addr);

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // A transfer is "active" from the cycle after acceptance up to and
    // including the cycle of the final handshake. Sample i must equal
    // (base + i) mod 2^AW; read i must address the same location.
    bit          act = 0, was_act, done_exp = 0, ren_due = 0, prev_stall = 0;
    int unsigned n = 0, issued = 0, popped = 0;
    logic [AW-1:0] mbase = '0, ea;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW-1:0] beat_q[$];
    bit            last_q[$];
    int            beat_cyc[$];

    always @(negedge clk) begin
        if (rst) begin
            act = 0; done_exp = 0; ren_due = 0; prev_stall = 0;
        end else begin
            was_act = act;
            chk("done", done, done_exp);
            chk("busy", busy, act);
            if (ren_due) chk("first_read", ram_ren, 1'b1);
            ren_due = 0;
            if (ram_ren) begin
                ea = mbase + AW'(issued);
                chk("read_addr", ram_addr, ea);
                chk("read_in_window", (issued < n) && act, 1'b1);
                issued++;
            end
            if (act) chk("outstanding_le4", (issued - popped) <= 4, 1'b1);
            if (!act) chk("idle_no_valid", m_valid, 1'b0);
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            done_exp = 0;
            if (m_valid && m_ready && was_act) begin
                ea = mbase + AW'(popped);
                chk("beat_data", m_data, DW'(ea));
                chk("beat_last", m_last, popped == n - 1);
                beat_q.push_back(m_data);
                last_q.push_back(m_last);
                beat_cyc.push_back(cyc);
                popped++;
                if (popped == n) begin act = 0; done_exp = 1; end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (start && !was_act) begin
                if (num_samples == '0) done_exp = 1;
                else begin
                    act = 1; n = num_samples; mbase = base_addr;
                    issued = 0; popped = 0; ren_due = 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int acc, acc2, dcyc;

    task automatic go(input logic [AW-1:0] b, input logic [AW:0] num);
        start = 1'b1; base_addr = b; num_samples = num; acc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        for (int i = 0; i < max; i++) begin
            if (done) begin dcyc = cyc; return; end
            @(posedge clk); #1;
        end
        chk("done_timeout", 1'b0, 1'b1);
        dcyc = -1;
    endtask

    task automatic clear_log();
        beat_q.delete(); last_q.delete(); beat_cyc.delete();
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_done"}, done, 1'b0);
        chk({name, "_ren"}, ram_ren, 1'b0);
        chk({name, "_addr"}, ram_addr, '0);
        chk({name, "_data"}, m_data, '0);
        chk({name, "_valid"}, m_valid, 1'b0);
        chk({name, "_last"}, m_last, 1'b0);
    endtask

    logic [15:0] lfsr;

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_samples = '0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic read: base 0x10, 5 samples, m_ready held high.
        clear_log();
        go(20'h10, 21'd5);
        wait_done(50);
        chk("basic_count", beat_q.size(), 5);
        if (beat_q.size() == 5) begin
            chk("basic_b0", beat_q[0], 32'h10);
            chk("basic_b4", beat_q[4], 32'h14);
            chk("basic_last3", last_q[3], 1'b0);
            chk("basic_last4", last_q[4], 1'b1);
            chk("basic_first_cyc", beat_cyc[0] - acc, 3);
            chk("basic_last_cyc", beat_cyc[4] - acc, 7);
        end
        chk("basic_done_cyc", dcyc - acc, 8);
        chk("basic_busy_in_done", busy, 1'b0);
        @(posedge clk); #1;

        // Wrap-around at the top of the address space.
        clear_log();
        go(20'hFFFFE, 21'd4);
        wait_done(50);
        chk("wrap_count", beat_q.size(), 4);
        if (beat_q.size() == 4) begin
            chk("wrap_b0", beat_q[0], 32'hFFFFE);
            chk("wrap_b1", beat_q[1], 32'hFFFFF);
            chk("wrap_b2", beat_q[2], 32'h0);
            chk("wrap_b3", beat_q[3], 32'h1);
        end
        @(posedge clk); #1;

        // Zero count: done in cycle 1, nothing else moves.
        clear_log();
        go(20'h55, 21'd0);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        chk("zero_ren", ram_ren, 1'b0);
        @(posedge clk); #1;
        chk("zero_done_clear", done, 1'b0);
        chk("zero_no_beats", beat_q.size(), 0);

        // Back-pressure: a long stall first, then pseudo-random ready.
        clear_log();
        lfsr = 16'hACE1;
        m_ready = 1'b0;
        go(20'h100, 21'd16);
        for (int i = 0; i < 400 && !done; i++) begin
            if (i >= 8) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                m_ready = lfsr[0];
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        wait_done(20);
        chk("bp_count", beat_q.size(), 16);
        if (beat_q.size() == 16) begin
            chk("bp_b0", beat_q[0], 32'h100);
            chk("bp_b15", beat_q[15], 32'h10F);
            chk("bp_last15", last_q[15], 1'b1);
        end
        @(posedge clk); #1;

        // Start pulse mid-transfer is ignored.
        clear_log();
        go(20'h40, 21'd6);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 20'h999; num_samples = 21'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50);
        chk("ign_count", beat_q.size(), 6);
        if (beat_q.size() == 6) chk("ign_b5", beat_q[5], 32'h45);
        @(posedge clk); #1;

        // Reset mid-transfer after 3 beats.
        clear_log();
        go(20'h200, 21'd10);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_beats_before", beat_q.size(), 3);
        rst = 1'b1;
        #1 chk_outputs_zero("async_rst");
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_no_done", done, 1'b0);
            @(posedge clk); #1;
        end
        clear_log();
        go(20'h0, 21'd2);
        wait_done(50);
        chk("post_rst_count", beat_q.size(), 2);
        if (beat_q.size() == 2) begin
            chk("post_rst_b0", beat_q[0], 32'h0);
            chk("post_rst_b1", beat_q[1], 32'h1);
        end
        @(posedge clk); #1;

        // Back-to-back: second start in the done cycle of the first.
        clear_log();
        go(20'h300, 21'd3);
        wait_done(50);
        chk("b2b_done_cyc", dcyc - acc, 6);
        go(20'h400, 21'd2);
        acc2 = acc;
        wait_done(50);
        chk("b2b_count", beat_q.size(), 5);
        if (beat_q.size() == 5) begin
            chk("b2b_b3", beat_q[3], 32'h400);
            chk("b2b_first_cyc", beat_cyc[3] - acc2, 3);
        end
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
